// File: rtl/dmem_arbiter_if.sv
// Signal bundle for dmem_arbiter: pipeline and loader request ports plus the RAM port.
// slave is the arbiter's view; master is the requesters together with the RAM.
interface dmem_arbiter_if;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_done;
  logic        m_err;
  logic [63:0] m_rdata;
  logic        m_stall;

  logic        l_req;
  logic        l_we;
  logic [63:0] l_addr;
  logic [63:0] l_wdata;
  logic        l_done;
  logic        l_err;
  logic [63:0] l_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output m_done, m_err, m_rdata, m_stall, l_done, l_err, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  m_done, m_err, m_rdata, m_stall, l_done, l_err, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data RAM between the pipeline memory stage and the program loader.
// Define DMEM_ARB_STARVE_EN to add the loader starvation guard (counter + priority override).
module dmem_arbiter #(
  parameter int ADDR_LIMIT = 256,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        own_l_r;
  logic        mem_en_r;
  logic        mem_we_r;
  logic [7:0]  mem_addr_r;
  logic [63:0] mem_wdata_r;
  logic        m_done_r;
  logic        m_err_r;
  logic        m_rd_r;
  logic        l_done_r;
  logic        l_err_r;
  logic        l_rd_r;

  logic        starve_hit_s;
  logic        pick_l_s;
  logic        grant_s;
  logic        valid_s;
  logic        sel_we_s;
  logic [63:0] sel_addr_s;
  logic [63:0] sel_wdata_s;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt_r;

  assign starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

  // Consecutive pipeline grants while the loader waits; any gap in l_req restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= CNT_W'(32'd0);
    end else if (state_r != IDLE) begin
      starve_cnt_r <= starve_cnt_r;
    end else if (!bus.l_req || (grant_s && pick_l_s)) begin
      starve_cnt_r <= CNT_W'(32'd0);
    end else if (grant_s && !starve_hit_s) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(32'd1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // No counter: the override can never fire, so the pipeline always wins ties.
  assign starve_hit_s = (STARVE_MAX < 0);
`endif

  assign pick_l_s    = bus.l_req & (~bus.m_req | starve_hit_s);
  assign sel_we_s    = pick_l_s ? bus.l_we    : bus.m_we;
  assign sel_addr_s  = pick_l_s ? bus.l_addr  : bus.m_addr;
  assign sel_wdata_s = pick_l_s ? bus.l_wdata : bus.m_wdata;
  assign valid_s     = (sel_addr_s < 64'(ADDR_LIMIT));

  // Next-state logic; IDLE holds off while a done pulse is out so that cycle's req is ignored.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if ((bus.m_req | bus.l_req) & ~(m_done_r | l_done_r)) begin
          grant_s      = 1'b1;
          state_next_s = valid_s ? ACCESS : ERR;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and owner latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      own_l_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      own_l_r <= grant_s ? pick_l_s : own_l_r;
    end
  end

  // Registered RAM strobes (live during ACCESS) and owner-steered completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 8'd0;
      mem_wdata_r <= 64'd0;
      m_done_r    <= 1'b0;
      m_err_r     <= 1'b0;
      m_rd_r      <= 1'b0;
      l_done_r    <= 1'b0;
      l_err_r     <= 1'b0;
      l_rd_r      <= 1'b0;
    end else begin
      mem_en_r    <= grant_s & valid_s;
      mem_we_r    <= grant_s & valid_s & sel_we_s;
      mem_addr_r  <= (grant_s & valid_s) ? sel_addr_s[7:0] : 8'd0;
      mem_wdata_r <= (grant_s & valid_s) ? sel_wdata_s : 64'd0;
      m_done_r    <= ((state_r == ACCESS) | (state_r == ERR)) & ~own_l_r;
      m_err_r     <= (state_r == ERR) & ~own_l_r;
      m_rd_r      <= (state_r == ACCESS) & ~mem_we_r & ~own_l_r;
      l_done_r    <= ((state_r == ACCESS) | (state_r == ERR)) & own_l_r;
      l_err_r     <= (state_r == ERR) & own_l_r;
      l_rd_r      <= (state_r == ACCESS) & ~mem_we_r & own_l_r;
    end
  end

  // RAM output is itself a register; the gate flags steer it to the owner in the done cycle.
  assign bus.m_rdata   = m_rd_r ? bus.mem_rdata : 64'd0;
  assign bus.l_rdata   = l_rd_r ? bus.mem_rdata : 64'd0;
  assign bus.m_done    = m_done_r;
  assign bus.m_err     = m_err_r;
  assign bus.l_done    = l_done_r;
  assign bus.l_err     = l_err_r;
  assign bus.m_stall   = bus.m_req & ~m_done_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table vectors, multi-cycle corner sequences,
// and randomized rounds against a transaction-level model with a shadow memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int ADDR_LIMIT = 256;
  localparam int STARVE_MAX = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();
  dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Synchronous RAM: read data appears the cycle after the enable.
  logic [63:0] ram [0:255];
  logic [63:0] ram_q;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 64'd0;
      ram_q <= 64'd0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] shadow [0:255];
  int mdl_cnt = 0;

  typedef struct {
    logic        loader;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Spec-level model: address check plus a flat memory array.
  task automatic mdl_access(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                            output bit err, output logic [63:0] rdata);
    err   = (addr >= 64'(ADDR_LIMIT));
    rdata = 64'd0;
    if (!err) begin
      if (we) shadow[addr[7:0]] = wdata;
      else    rdata = shadow[addr[7:0]];
    end
  endtask

  function automatic bit mdl_pick_l(input bit p, input bit l);
    return l && (!p || (STARVE_EN && mdl_cnt == STARVE_MAX));
  endfunction

  task automatic mdl_grant(input bit l_won, input bit l_waiting);
    if (l_won || !l_waiting) mdl_cnt = 0;
    else if (mdl_cnt < STARVE_MAX) mdl_cnt++;
  endtask

  task automatic drop_all();
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = 64'd0; bus.m_wdata = 64'd0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 64'd0; bus.l_wdata = 64'd0;
  endtask

  // One isolated transaction; reports latency (negedges after issue), results and side counts.
  task automatic run_txn(input bit ldr, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         output int lat, output bit err, output logic [63:0] rdata,
                         output int en_cnt, output int we_cnt, output bit stall_ok, output bit other_bad);
    @(posedge clk); #1;
    if (ldr) begin bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata; end
    else     begin bus.m_req = 1'b1; bus.m_we = we; bus.m_addr = addr; bus.m_wdata = wdata; end
    lat = -1; err = 1'b0; rdata = 64'd0; en_cnt = 0; we_cnt = 0; stall_ok = 1'b1; other_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (bus.mem_we) we_cnt++;
      if (ldr) other_bad |= bus.m_done | bus.m_err | (bus.m_rdata != 64'd0);
      else     other_bad |= bus.l_done | bus.l_err | (bus.l_rdata != 64'd0);
      if (ldr ? bus.l_done : bus.m_done) begin
        lat = c; err = ldr ? bus.l_err : bus.m_err; rdata = ldr ? bus.l_rdata : bus.m_rdata;
        if (!ldr && bus.m_stall) stall_ok = 1'b0;
        break;
      end
      if (!ldr && !bus.m_stall) stall_ok = 1'b0;
    end
    @(posedge clk); #1;
    drop_all();
  endtask

  // Reset lands while a loader access sits in ACCESS; optionally the loader reissues.
  task automatic rst_mid_access(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                                input bit reissue);
    bit e; logic [63:0] rd; int lat;
    @(posedge clk); #1;
    bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
    @(negedge clk); @(negedge clk);
    check("rst_access_en", bus.mem_en, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_outputs_zero", 64'(|{bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
          bus.m_done, bus.m_err, bus.m_rdata, bus.l_done, bus.l_err, bus.l_rdata}), 64'd0);
    rst = 1'b0;
    if (!reissue) begin
      drop_all();
    end else begin
      lat = -1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.l_done) begin lat = c; break; end
      end
      mdl_access(we, addr, wdata, e, rd);
      check("rst_reissue_lat", 64'(lat), 64'd2);
      check("rst_reissue_rdata", bus.l_rdata, rd);
      @(posedge clk); #1;
      drop_all();
    end
  endtask

  initial begin
    int lat, en_cnt, we_cnt, g;
    bit err, stall_ok, other_bad, e, exp_l, do_p, do_l, pw, lw, p_pend, l_pend, n_first, drop;
    logic [63:0] rd, pa, la, pd, ld;
    int mode;

    for (int i = 0; i < 256; i++) shadow[i] = 64'd0;
    drop_all();
    rst = 1'b1; ram_clr = 1'b1;
    vecs[0]  = '{1'b0, 1'b1, 64'h10,  64'hDEAD, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 64'h10,  64'h0,    1'b0, 64'hDEAD};
    vecs[2]  = '{1'b1, 1'b1, 64'h20,  64'h55,   1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b0, 64'h20,  64'h0,    1'b0, 64'h55};
    vecs[4]  = '{1'b0, 1'b0, 64'd256, 64'h0,    1'b1, 64'h0};
    vecs[5]  = '{1'b1, 1'b0, 64'd300, 64'h0,    1'b1, 64'h0};
    vecs[6]  = '{1'b1, 1'b1, 64'd255, 64'hA5A5, 1'b0, 64'h0};
    vecs[7]  = '{1'b1, 1'b0, 64'd255, 64'h0,    1'b0, 64'hA5A5};
    vecs[8]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h0};
    vecs[9]  = '{1'b0, 1'b1, 64'h0,   64'h1234, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 1'b0, 64'h0,   64'h0,    1'b0, 64'h1234};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(|{bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.m_done,
          bus.m_err, bus.m_rdata, bus.m_stall, bus.l_done, bus.l_err, bus.l_rdata}), 64'd0);
    rst = 1'b0; ram_clr = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].loader, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              lat, err, rd, en_cnt, we_cnt, stall_ok, other_bad);
      mdl_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, e, pd);
      check("vec_latency", 64'(lat), 64'd2);
      check("vec_err", err, vecs[i].exp_err);
      check("vec_rdata", rd, vecs[i].exp_rdata);
      check("vec_mem_en_count", 64'(en_cnt), vecs[i].exp_err ? 64'd0 : 64'd1);
      check("vec_mem_we_count", 64'(we_cnt), (!vecs[i].exp_err && vecs[i].we) ? 64'd1 : 64'd0);
      check("vec_stall", stall_ok, 1'b1);
      check("vec_nonowner_quiet", other_bad, 1'b0);
    end

    // Both requesters hold reads continuously; model decides each winner.
    repeat (2) @(posedge clk); #1;
    mdl_cnt = 0;
    bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 64'h10;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 64'h20;
    g = 0;
    for (int c = 0; c < 100 && g < 10; c++) begin
      @(negedge clk);
      if (bus.m_done || bus.l_done) begin
        exp_l = mdl_pick_l(1'b1, 1'b1);
        check("starve_order", bus.l_done, exp_l);
        if (bus.l_done) check("starve_l_rdata", bus.l_rdata, shadow[8'h20]);
        else            check("starve_m_rdata", bus.m_rdata, shadow[8'h10]);
        mdl_grant(bus.l_done, 1'b1);
        g++;
      end
    end
    check("starve_grants", 64'(g), 64'd10);
    @(posedge clk); #1;
    drop_all();

    rst_mid_access(1'b0, 64'h20, 64'h0, 1'b1);
    rst_mid_access(1'b1, 64'h30, 64'h77, 1'b0);
    shadow[8'h30] = 64'h77;
    run_txn(1'b0, 1'b0, 64'h30, 64'h0, lat, err, rd, en_cnt, we_cnt, stall_ok, other_bad);
    check("rst_write_committed", rd, 64'h77);

    for (int r = 0; r < 60; r++) begin
      mode = int'($urandom_range(0, 2));
      do_p = (mode != 1); do_l = (mode != 0);
      pw = 1'($urandom_range(0, 1)); lw = 1'($urandom_range(0, 1));
      pa = ($urandom_range(0, 7) == 0) ? 64'(ADDR_LIMIT) + 64'($urandom_range(0, 1000))
                                       : 64'($urandom_range(0, ADDR_LIMIT - 1));
      la = ($urandom_range(0, 7) == 0) ? 64'(ADDR_LIMIT) + 64'($urandom_range(0, 1000))
                                       : 64'($urandom_range(0, ADDR_LIMIT - 1));
      pd = {$urandom, $urandom}; ld = {$urandom, $urandom};
      mdl_cnt = 0;
      n_first = 1'b1;
      @(posedge clk); #1;
      bus.m_req = do_p; bus.m_we = pw; bus.m_addr = pa; bus.m_wdata = pd;
      bus.l_req = do_l; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld;
      p_pend = do_p; l_pend = do_l; other_bad = 1'b0;
      for (int c = 0; c < 20 && (p_pend || l_pend); c++) begin
        @(negedge clk);
        other_bad |= (!bus.m_done && (bus.m_err || bus.m_rdata != 64'd0));
        other_bad |= (!bus.l_done && (bus.l_err || bus.l_rdata != 64'd0));
        other_bad |= (bus.m_done && bus.l_done);
        drop = 1'b0;
        if (bus.m_done || bus.l_done) begin
          exp_l = mdl_pick_l(p_pend, l_pend);
          check("rand_order", bus.l_done, exp_l);
          mdl_grant(bus.l_done, l_pend);
          if (bus.l_done) begin
            mdl_access(lw, la, ld, e, rd);
            check("rand_l_err", bus.l_err, e);
            check("rand_l_rdata", bus.l_rdata, rd);
            l_pend = 1'b0;
          end else begin
            mdl_access(pw, pa, pd, e, rd);
            check("rand_m_err", bus.m_err, e);
            check("rand_m_rdata", bus.m_rdata, rd);
            p_pend = 1'b0;
          end
          n_first = 1'b0;
          drop = 1'b1;
        end
        if (drop) begin
          @(posedge clk); #1;
          if (!p_pend) bus.m_req = 1'b0;
          if (!l_pend) bus.l_req = 1'b0;
        end
      end
      check("rand_complete", {62'd0, p_pend, l_pend}, 64'd0);
      check("rand_nonowner_quiet", other_bad, 1'b0);
      drop_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
